// File: rtl/ddr_test_pkg.sv
// rtl/ddr_test_pkg.sv - shared types, defaults and pattern helper for the DDR test engine
package ddr_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ADDR,
    ST_WR_DATA,
    ST_RD_ADDR,
    ST_RD_DATA
  } ddr_test_state_e;

  // Default geometry: one 16-beat burst of 128-bit words spans 256 bytes,
  // and the default window is 256 such bursts.
  localparam int DEF_DATA_WIDTH  = 128;
  localparam int DEF_BURST_LEN   = 16;
  localparam int DEF_ADDR_BASE   = 0;
  localparam int DEF_BURST_SPAN  = DEF_BURST_LEN * DEF_DATA_WIDTH / 8;
  localparam int DEF_TEST_BYTES  = 256 * DEF_BURST_SPAN;
  localparam int DEF_WINDOW_END  = DEF_ADDR_BASE + DEF_TEST_BYTES;

  // Widest data bus the pattern helper can fill.
  localparam int PAT_MAX_WIDTH = 1024;

  function automatic int burst_span(input int burst_len, input int data_width);
    return burst_len * data_width / 8;
  endfunction

  function automatic int window_end(input int base, input int bytes);
    return base + bytes;
  endfunction

  // Address-derived word, optionally inverted, replicated across data_width bits.
  function automatic logic [PAT_MAX_WIDTH-1:0] ddr_test_pattern(
    input logic [31:0] addr,
    input logic        polarity,
    input int          data_width
  );
    logic [31:0]              word;
    logic [PAT_MAX_WIDTH-1:0] pat;
    word = addr ^ {32{polarity}};
    pat  = '0;
    for (int i = 0; i < PAT_MAX_WIDTH / 32; i++) begin
      if (i < data_width / 32) pat[i*32 +: 32] = word;
    end
    return pat;
  endfunction

endpackage

// File: rtl/ddr_test_engine_if.sv
// rtl/ddr_test_engine_if.sv - AXI4 user-port subset driven by the DDR test engine
interface ddr_test_engine_if #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 28
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awlen, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    output araddr, arlen, arvalid, input arready,
    input  rdata, rlast, rvalid, output rready
  );

  modport slave (
    input  awaddr, awlen, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    input  araddr, arlen, arvalid, output arready,
    output rdata, rlast, rvalid, input rready
  );
endinterface

// File: rtl/ddr_test_hb.sv
// rtl/ddr_test_hb.sv - free-running heartbeat divider for the DDR test engine
module ddr_test_hb #(
  parameter int HB_BITS = 24
) (
  input  logic clk,
  input  logic rst,
  output logic heart_beat
);
  logic [HB_BITS-1:0] cnt;

  // Count every cycle and toggle the output each time the counter wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      heart_beat <= 1'b0;
    end else begin
      cnt <= cnt + HB_BITS'(1);
      if (&cnt) heart_beat <= ~heart_beat;
    end
  end
endmodule

// File: rtl/ddr_test_engine.sv
// rtl/ddr_test_engine.sv - write/read-back DDR traffic checker; optional DDR_TEST_ERR_INJECT_EN
module ddr_test_engine
  import ddr_test_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = 28,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int ADDR_BASE  = DEF_ADDR_BASE,
  parameter int TEST_BYTES = DEF_TEST_BYTES,
  parameter int HB_BITS    = 24
) (
  input  logic                 core_clk,
  input  logic                 ddr_rst,
  input  logic                 ddr_init_done,
`ifdef DDR_TEST_ERR_INJECT_EN
  input  logic                 err_inject,
`endif
  ddr_test_engine_if.master    axi,
  output logic                 err_flag,
  output logic [15:0]          err_cnt,
  output logic [15:0]          pass_cnt,
  output logic                 heart_beat
);
  localparam int                    BEAT_BYTES = DATA_WIDTH / 8;
  localparam int                    SPAN       = burst_span(BURST_LEN, DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0]   WIN_END    = (ADDR_WIDTH+1)'(window_end(ADDR_BASE, TEST_BYTES));
  localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(ADDR_BASE);
  localparam logic [7:0]            LEN        = 8'(BURST_LEN - 1);
  localparam logic [8:0]            LAST_BEAT  = 9'(BURST_LEN - 1);

  ddr_test_state_e       state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [8:0]            beat;

  logic [ADDR_WIDTH-1:0] next_beat_addr;
  logic [ADDR_WIDTH:0]   next_burst;
  logic                  window_done;
  logic [ADDR_WIDTH-1:0] wr_pat_addr;
  logic [DATA_WIDTH-1:0] wr_pattern;
  logic [DATA_WIDTH-1:0] rd_pattern;
  logic [DATA_WIDTH-1:0] wr_flip;
  logic                  load_beat;

  // One extra address bit so a window ending at the top of the space still compares.
  assign next_beat_addr = beat_addr + ADDR_WIDTH'(BEAT_BYTES);
  assign next_burst     = {1'b0, cur_addr} + (ADDR_WIDTH+1)'(SPAN);
  assign window_done    = (next_burst == WIN_END);
  assign load_beat      = (state == ST_WR_ADDR && axi.awready) ||
                          (state == ST_WR_DATA && axi.wready && beat != LAST_BEAT);

  // Pattern for the beat about to be loaded into wdata, and for the beat being read back.
  always_comb begin
    wr_pat_addr = (state == ST_WR_ADDR) ? cur_addr : next_beat_addr;
    wr_pattern  = DATA_WIDTH'(ddr_test_pattern(32'(wr_pat_addr), pass_cnt[0], DATA_WIDTH));
    rd_pattern  = DATA_WIDTH'(ddr_test_pattern(32'(beat_addr), pass_cnt[0], DATA_WIDTH));
  end

`ifdef DDR_TEST_ERR_INJECT_EN
  logic inj_q;
  logic inj_armed;

  // Arm on a rising edge of err_inject; the next loaded write beat consumes it.
  always_ff @(posedge core_clk or posedge ddr_rst) begin
    if (ddr_rst) begin
      inj_q     <= 1'b0;
      inj_armed <= 1'b0;
    end else begin
      inj_q <= err_inject;
      if (load_beat)                inj_armed <= 1'b0;
      else if (err_inject && !inj_q) inj_armed <= 1'b1;
    end
  end

  assign wr_flip = {{(DATA_WIDTH-1){1'b0}}, inj_armed && load_beat};
`else
  assign wr_flip = '0;
`endif

  // Main sequencer: one transaction in flight, all AXI outputs and status registered.
  always_ff @(posedge core_clk or posedge ddr_rst) begin
    if (ddr_rst) begin
      state       <= ST_IDLE;
      cur_addr    <= BASE;
      beat_addr   <= BASE;
      beat        <= '0;
      axi.awaddr  <= BASE;
      axi.awlen   <= LEN;
      axi.awvalid <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.wlast   <= 1'b0;
      axi.wvalid  <= 1'b0;
      axi.araddr  <= BASE;
      axi.arlen   <= LEN;
      axi.arvalid <= 1'b0;
      axi.rready  <= 1'b0;
      err_flag    <= 1'b0;
      err_cnt     <= '0;
      pass_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ddr_init_done) begin
            axi.awvalid <= 1'b1;
            axi.awaddr  <= cur_addr;
            state       <= ST_WR_ADDR;
          end
        end
        ST_WR_ADDR: begin
          if (axi.awready) begin
            axi.awvalid <= 1'b0;
            axi.wvalid  <= 1'b1;
            axi.wstrb   <= '1;
            axi.wdata   <= wr_pattern ^ wr_flip;
            axi.wlast   <= (LAST_BEAT == 9'd0);
            beat        <= '0;
            beat_addr   <= cur_addr;
            state       <= ST_WR_DATA;
          end
        end
        ST_WR_DATA: begin
          if (axi.wready) begin
            if (beat == LAST_BEAT) begin
              axi.wvalid <= 1'b0;
              axi.wlast  <= 1'b0;
              if (window_done) begin
                cur_addr    <= BASE;
                axi.arvalid <= 1'b1;
                axi.araddr  <= BASE;
                state       <= ST_RD_ADDR;
              end else begin
                cur_addr    <= next_burst[ADDR_WIDTH-1:0];
                axi.awvalid <= 1'b1;
                axi.awaddr  <= next_burst[ADDR_WIDTH-1:0];
                state       <= ST_WR_ADDR;
              end
            end else begin
              beat      <= beat + 9'd1;
              beat_addr <= next_beat_addr;
              axi.wdata <= wr_pattern ^ wr_flip;
              axi.wlast <= (beat + 9'd1 == LAST_BEAT);
            end
          end
        end
        ST_RD_ADDR: begin
          if (axi.arready) begin
            axi.arvalid <= 1'b0;
            axi.rready  <= 1'b1;
            beat_addr   <= cur_addr;
            state       <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          // rready is always high here, so rvalid alone marks a handshake.
          if (axi.rvalid) begin
            if (axi.rdata != rd_pattern) begin
              err_flag <= 1'b1;
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end
            beat_addr <= next_beat_addr;
            if (axi.rlast) begin
              axi.rready <= 1'b0;
              if (window_done) begin
                cur_addr    <= BASE;
                pass_cnt    <= pass_cnt + 16'd1;
                axi.awvalid <= 1'b1;
                axi.awaddr  <= BASE;
                state       <= ST_WR_ADDR;
              end else begin
                cur_addr    <= next_burst[ADDR_WIDTH-1:0];
                axi.arvalid <= 1'b1;
                axi.araddr  <= next_burst[ADDR_WIDTH-1:0];
                state       <= ST_RD_ADDR;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ddr_test_hb #(.HB_BITS(HB_BITS)) u_hb (
    .clk        (core_clk),
    .rst        (ddr_rst),
    .heart_beat (heart_beat)
  );
endmodule

// File: tb/tb_ddr_test_engine.sv
// tb/tb_ddr_test_engine.sv - randomized bench for ddr_test_engine against a window/pass model
`timescale 1ns/1ps
module tb_ddr_test_engine;
  localparam int DW     = 128;
  localparam int AW     = 28;
  localparam int BL     = 4;
  localparam int BASE   = 0;
  localparam int WBYTES = 256;
  localparam int HB     = 4;
  localparam int BEAT   = DW / 8;
  localparam int SPAN   = BL * BEAT;
  localparam int NBURST = WBYTES / SPAN;

  logic        clk       = 1'b0;
  logic        rst       = 1'b0;
  logic        init_done = 1'b0;
  logic        err_flag;
  logic [15:0] err_cnt;
  logic [15:0] pass_cnt;
  logic        heart_beat;
`ifdef DDR_TEST_ERR_INJECT_EN
  logic        err_inject = 1'b0;
`endif

  ddr_test_engine_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) axi ();

  ddr_test_engine #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .BURST_LEN  (BL),
    .ADDR_BASE  (BASE),
    .TEST_BYTES (WBYTES),
    .HB_BITS    (HB)
  ) dut (
    .core_clk      (clk),
    .ddr_rst       (rst),
    .ddr_init_done (init_done),
`ifdef DDR_TEST_ERR_INJECT_EN
    .err_inject    (err_inject),
`endif
    .axi           (axi),
    .err_flag      (err_flag),
    .err_cnt       (err_cnt),
    .pass_cnt      (pass_cnt),
    .heart_beat    (heart_beat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_ok     = 0;

  // Reference model state: which pass/phase/burst the engine should be in.
  int          m_pass, m_phase, m_idx, m_err_cnt, cyc;
  bit          m_err_flag;
  int          stall_max   = 0;
  int          corrupt_pass = -1;
  int          aw_total, ar_total;
  // Slave state.
  int          aw_stall, w_stall, ar_stall, w_beat, r_left, r_beat;
  int unsigned r_addr;
  bit          r_hold, r_corrupt;
  logic [127:0] mem [int unsigned];
  // Previous-cycle observations for hold/stability checks.
  bit           p_aw_wait, p_w_wait, p_ar_wait, p_w_more;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [DW-1:0] p_wdata;
  logic          p_wlast;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [127:0] pat(input int unsigned addr, input int pass);
    logic [31:0] w;
    w = addr ^ (((pass % 2) != 0) ? 32'hFFFF_FFFF : 32'h0);
    return {4{w}};
  endfunction

  // One clock: sample at negedge, check, then drive slave inputs for the next posedge.
  task automatic cycle();
    bit aw_hs, w_hs, ar_hs, r_hs;
    int unsigned a;
    @(negedge clk);
    if (!rst) cyc++;
    check("heart_beat", heart_beat, 128'((cyc / 16) % 2));
    check("pass_cnt", pass_cnt, 128'(m_pass));
    check("err_flag", err_flag, 128'(m_err_flag));
    check("err_cnt", err_cnt, 128'(m_err_cnt));
    check("one_active", 128'($countones({axi.awvalid, axi.wvalid, axi.arvalid, axi.rready}) <= 1), 1);
    if (p_aw_wait) check("aw_hold", {axi.awvalid, axi.awaddr}, {1'b1, p_awaddr});
    if (p_ar_wait) check("ar_hold", {axi.arvalid, axi.araddr}, {1'b1, p_araddr});
    if (p_w_wait)  check("w_hold", {axi.wvalid, axi.wlast, axi.wdata}, {1'b1, p_wlast, p_wdata});
    if (p_w_more)  check("w_b2b", axi.wvalid, 1);

    axi.awready = 1'b0;
    if (axi.awvalid) begin
      if (aw_stall > 0) aw_stall--; else axi.awready = 1'b1;
    end
    aw_hs = axi.awvalid && axi.awready;
    if (aw_hs) begin
      check("aw_phase", 128'(m_phase), 0);
      check("awaddr", axi.awaddr, 128'(BASE + m_idx * SPAN));
      check("awlen", axi.awlen, BL - 1);
      aw_total++;
      w_beat   = 0;
      aw_stall = $urandom_range(0, stall_max);
    end

    axi.wready = 1'b0;
    if (axi.wvalid) begin
      if (w_stall > 0) w_stall--; else axi.wready = 1'b1;
    end
    w_hs = axi.wvalid && axi.wready;
    if (w_hs) begin
      a = BASE + m_idx * SPAN + w_beat * BEAT;
      check("wdata", axi.wdata, pat(a, m_pass));
      check("wlast", axi.wlast, 128'(w_beat == BL - 1));
      check("wstrb", axi.wstrb, 16'hFFFF);
      if (a == 32'h50 && m_pass % 2 == 0) check("wdata_50", axi.wdata, {4{32'h0000_0050}});
      if (a == 32'h50 && m_pass % 2 == 1) check("wdata_50_inv", axi.wdata, {4{32'hFFFF_FFAF}});
      mem[a]  = axi.wdata;
      w_stall = $urandom_range(0, stall_max);
      if (w_beat == BL - 1) begin
        w_beat = 0;
        m_idx++;
        if (m_idx == NBURST) begin m_idx = 0; m_phase = 1; end
      end else w_beat++;
    end

    axi.arready = 1'b0;
    if (axi.arvalid) begin
      if (ar_stall > 0) ar_stall--; else axi.arready = 1'b1;
    end
    ar_hs = axi.arvalid && axi.arready;
    if (ar_hs) begin
      check("ar_phase", 128'(m_phase), 1);
      check("araddr", axi.araddr, 128'(BASE + m_idx * SPAN));
      check("arlen", axi.arlen, BL - 1);
      ar_total++;
      r_left   = BL;
      r_beat   = 0;
      r_addr   = BASE + m_idx * SPAN;
      ar_stall = $urandom_range(0, stall_max);
    end

    if (!r_hold) begin
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      r_corrupt  = 1'b0;
      if (r_left > 0 && (stall_max == 0 || $urandom_range(0, 2) != 0)) begin
        axi.rvalid = 1'b1;
        axi.rdata  = mem.exists(r_addr) ? mem[r_addr] : '0;
        r_corrupt  = (m_pass == corrupt_pass) && (r_addr == 32'h90);
        if (r_corrupt) axi.rdata[7] = ~axi.rdata[7];
        axi.rlast  = (r_beat == BL - 1);
      end
    end
    r_hs   = axi.rvalid && axi.rready;
    r_hold = axi.rvalid && !r_hs;
    if (r_hs) begin
      if (r_corrupt) begin
        m_err_flag = 1'b1;
        if (m_err_cnt < 65535) m_err_cnt++;
      end
      r_addr += BEAT;
      r_beat++;
      r_left--;
      if (r_left == 0) begin
        m_idx++;
        if (m_idx == NBURST) begin m_idx = 0; m_phase = 0; m_pass = (m_pass + 1) % 65536; end
      end
    end

    p_aw_wait = axi.awvalid && !aw_hs;
    p_ar_wait = axi.arvalid && !ar_hs;
    p_w_wait  = axi.wvalid && !w_hs;
    p_w_more  = w_hs && !axi.wlast;
    p_awaddr  = axi.awaddr;
    p_araddr  = axi.araddr;
    p_wdata   = axi.wdata;
    p_wlast   = axi.wlast;
  endtask

  task automatic do_reset(input bit keep_init);
    rst = 1'b1;
    if (!keep_init) init_done = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
    axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rdata = '0;
    m_pass = 0; m_phase = 0; m_idx = 0; m_err_cnt = 0; m_err_flag = 1'b0; cyc = 0;
    aw_total = 0; ar_total = 0; aw_stall = 0; w_stall = 0; ar_stall = 0;
    w_beat = 0; r_left = 0; r_beat = 0; r_hold = 1'b0; r_corrupt = 1'b0;
    p_aw_wait = 1'b0; p_ar_wait = 1'b0; p_w_wait = 1'b0; p_w_more = 1'b0;
    cycle();
    check("rst_valids", {axi.awvalid, axi.wvalid, axi.wlast, axi.arvalid, axi.rready}, 0);
    check("rst_awaddr", axi.awaddr, BASE);
    check("rst_araddr", axi.araddr, BASE);
    check("rst_lens", {axi.awlen, axi.arlen}, {8'(BL - 1), 8'(BL - 1)});
    check("rst_wdata", axi.wdata, 0);
    check("rst_wstrb", axi.wstrb, 0);
    rst = 1'b0;
    cyc = 0;
    if (!keep_init) begin
      repeat ($urandom_range(2, 5)) begin
        cycle();
        check("idle_quiet", {axi.awvalid, axi.wvalid, axi.arvalid, axi.rready}, 0);
      end
      init_done = 1'b1;
    end
    cycle();
    check("aw_latency", axi.awvalid, 1);
  endtask

  task automatic run_until_pass(input int target);
    int budget;
    budget = 3000;
    while (m_pass < target && budget > 0) begin
      cycle();
      budget--;
    end
    check("pass_reached", 128'(m_pass), 128'(target));
  endtask

  initial begin
    int budget;
    #2;
    stall_max = 0;
    do_reset(1'b0);

    run_until_pass(1);
    check("aw_bursts", 128'(aw_total), NBURST);
    check("ar_bursts", 128'(ar_total), NBURST);
    cycle();
    check("pass1_cnt", pass_cnt, 1);
    check("pass1_err", err_flag, 0);

    stall_max = 5;
    run_until_pass(2);
    corrupt_pass = 2;
    run_until_pass(4);
    cycle();
    check("err_cnt_corrupt", err_cnt, 1);
    check("err_sticky", err_flag, 1);

    budget = 500;
    while (!(m_phase == 0 && w_beat == 2) && budget > 0) begin
      cycle();
      budget--;
    end
    w_stall = 3;
    cycle();
    check("mid_wvalid", axi.wvalid, 1);
    do_reset(1'b1);

    stall_max = 0;
    corrupt_pass = -1;
    run_until_pass(1);
    cycle();
    check("post_rst_pass", pass_cnt, 1);
    check("post_rst_err", err_flag, 0);

    $display("%0d/%0d checks passed", n_ok, n_checks);
    $finish;
  end
endmodule
